// File: rtl/datapath_sequencer.sv
// Instruction register, decoder and Moore FSM that sequences the 16-bit
// register-file/ALU datapath, executing one instruction per start request.
module datapath_sequencer #(
   parameter int m = 16
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [m-1:0] in,
   input  logic         load,
   input  logic         s,
   input  logic         status,
   output logic         w,
   output logic         vsel,
   output logic         asel,
   output logic         bsel,
   output logic         loada,
   output logic         loadb,
   output logic         loadc,
   output logic         loads,
   output logic         write,
   output logic [2:0]   readnum,
   output logic [2:0]   writenum,
   output logic [1:0]   ALUop,
   output logic [1:0]   shift,
   output logic [m-1:0] datapath_in,
   output logic [m-1:0] sximm5
);

   typedef enum logic [2:0] {
      S_WAIT,
      S_DECODE,
      S_WRITE_IMM,
      S_GET_A,
      S_GET_B,
      S_EXEC,
      S_WRITE_REG
   } state_t;

   state_t       r_state;
   state_t       w_next_state;
   logic [m-1:0] r_ir;

   logic [2:0] w_opcode;
   logic [1:0] w_op;
   logic [2:0] w_rn;
   logic [2:0] w_rd;
   logic [1:0] w_sh;
   logic [2:0] w_rm;
   logic       w_mov_imm;
   logic       w_mov_reg;
   logic       w_alu_grp;
   logic       w_cmp;
   logic       w_mvn;
   logic       w_b_only;
   logic       w_unused_status;

   assign w_opcode = r_ir[15:13];
   assign w_op     = r_ir[12:11];
   assign w_rn     = r_ir[10:8];
   assign w_rd     = r_ir[7:5];
   assign w_sh     = r_ir[4:3];
   assign w_rm     = r_ir[2:0];

   assign w_mov_imm = (w_opcode == 3'b110) && (w_op == 2'b10);
   assign w_mov_reg = (w_opcode == 3'b110) && (w_op == 2'b00);
   assign w_alu_grp = (w_opcode == 3'b101);
   assign w_cmp     = w_alu_grp && (w_op == 2'b01);
   assign w_mvn     = w_alu_grp && (w_op == 2'b11);
   // MOV reg and MVN only need the B operand; A is forced to zero in EXEC.
   assign w_b_only  = w_mov_reg || w_mvn;

   // The zero flag is observed by the datapath user only; no branches exist.
   assign w_unused_status = status;

   assign datapath_in = {{(m-8){r_ir[7]}}, r_ir[7:0]};
   assign sximm5      = {{(m-5){r_ir[4]}}, r_ir[4:0]};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_WAIT;
         r_ir    <= '0;
      end else begin
         r_state <= w_next_state;
         if ((r_state == S_WAIT) && load)
            r_ir <= in;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w        = 1'b0;
      vsel     = 1'b0;
      asel     = 1'b0;
      bsel     = 1'b0;
      loada    = 1'b0;
      loadb    = 1'b0;
      loadc    = 1'b0;
      loads    = 1'b0;
      write    = 1'b0;
      readnum  = 3'd0;
      writenum = 3'd0;
      ALUop    = 2'b00;
      shift    = 2'b00;
      case (r_state)
         S_WAIT: begin
            w = 1'b1;
            if (s)
               w_next_state = S_DECODE;
         end
         S_DECODE: begin
            if (w_mov_imm)
               w_next_state = S_WRITE_IMM;
            else if (w_b_only)
               w_next_state = S_GET_B;
            else if (w_alu_grp)
               w_next_state = S_GET_A;
            else
               w_next_state = S_WAIT;
         end
         S_WRITE_IMM: begin
            write        = 1'b1;
            writenum     = w_rn;
            w_next_state = S_WAIT;
         end
         S_GET_A: begin
            loada        = 1'b1;
            readnum      = w_rn;
            w_next_state = S_GET_B;
         end
         S_GET_B: begin
            loadb        = 1'b1;
            readnum      = w_rm;
            shift        = w_sh;
            w_next_state = S_EXEC;
         end
         S_EXEC: begin
            shift = w_sh;
            asel  = w_b_only;
            ALUop = w_alu_grp ? w_op : 2'b00;
            // CMP only updates the status flag, never the result register.
            if (w_cmp) begin
               loads        = 1'b1;
               w_next_state = S_WAIT;
            end else begin
               loadc        = 1'b1;
               w_next_state = S_WRITE_REG;
            end
         end
         S_WRITE_REG: begin
            write        = 1'b1;
            vsel         = 1'b1;
            writenum     = w_rd;
            w_next_state = S_WAIT;
         end
         default: w_next_state = S_WAIT;
      endcase
   end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer: a behavioural datapath driven by the DUT
// controls, checked against an instruction-level reference model.
module tb_datapath_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] in;
   logic        load;
   logic        s;
   logic        status;
   logic        w, vsel, asel, bsel, loada, loadb, loadc, loads, write;
   logic [2:0]  readnum, writenum;
   logic [1:0]  ALUop, shift;
   logic [15:0] datapath_in, sximm5;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   datapath_sequencer #(.m(16)) dut (
      .clk(clk), .reset_n(reset_n), .in(in), .load(load), .s(s), .status(status),
      .w(w), .vsel(vsel), .asel(asel), .bsel(bsel), .loada(loada), .loadb(loadb),
      .loadc(loadc), .loads(loads), .write(write), .readnum(readnum),
      .writenum(writenum), .ALUop(ALUop), .shift(shift),
      .datapath_in(datapath_in), .sximm5(sximm5)
   );

   // Datapath driven by the sequencer controls
   logic [15:0] dp_R [8] = '{default: 16'h0};
   logic [15:0] dp_A = 16'h0, dp_B = 16'h0, dp_C = 16'h0;
   logic        dp_status = 1'b0;
   logic [15:0] dp_sout, dp_ain, dp_bin, dp_alu;

   always_comb begin
      dp_sout = dp_B;
      case (shift)
         2'b01:   dp_sout = {dp_B[14:0], 1'b0};
         2'b10:   dp_sout = {1'b0, dp_B[15:1]};
         2'b11:   dp_sout = {dp_B[15], dp_B[15:1]};
         default: dp_sout = dp_B;
      endcase
      dp_ain = asel ? 16'h0 : dp_A;
      dp_bin = bsel ? sximm5 : dp_sout;
      case (ALUop)
         2'b00:   dp_alu = dp_ain + dp_bin;
         2'b01:   dp_alu = dp_ain - dp_bin;
         2'b10:   dp_alu = dp_ain & dp_bin;
         default: dp_alu = ~dp_bin;
      endcase
   end

   always @(posedge clk) begin
      if (loada) dp_A <= dp_R[readnum];
      if (loadb) dp_B <= dp_R[readnum];
      if (loadc) dp_C <= dp_alu;
      if (loads) dp_status <= (dp_alu == 16'h0);
      if (write) dp_R[writenum] <= vsel ? dp_C : datapath_in;
   end

   assign status = dp_status;

   // Instruction-level reference model
   logic [15:0] ref_R [8] = '{default: 16'h0};
   logic        ref_status = 1'b0;

   function automatic logic [15:0] shv(input logic [15:0] b, input logic [1:0] sh);
      case (sh)
         2'd1:    return b * 16'd2;
         2'd2:    return b / 16'd2;
         2'd3:    return 16'($signed(b) >>> 1);
         default: return b;
      endcase
   endfunction

   task automatic ref_exec(input logic [15:0] ins, output int lat, output int wr);
      logic [15:0] a, b, res;
      a   = ref_R[ins[10:8]];
      b   = shv(ref_R[ins[2:0]], ins[4:3]);
      lat = 1;
      wr  = 0;
      case (ins[15:11])
         5'b11010: begin ref_R[ins[10:8]] = {{8{ins[7]}}, ins[7:0]}; lat = 2; wr = 1; end
         5'b11000: begin ref_R[ins[7:5]] = b;      lat = 4; wr = 1; end
         5'b10100: begin ref_R[ins[7:5]] = a + b;  lat = 5; wr = 1; end
         5'b10101: begin res = a - b; ref_status = (res == 16'h0); lat = 4; end
         5'b10110: begin ref_R[ins[7:5]] = a & b;  lat = 5; wr = 1; end
         5'b10111: begin ref_R[ins[7:5]] = ~b;     lat = 4; wr = 1; end
         default: ;
      endcase
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_instr(input logic [15:0] ins, output int lat, output int nwr,
                            output int nlda, output int nldc, output int nlds);
      in   = ins;
      load = 1'b1;
      step();
      load = 1'b0;
      s    = 1'b1;
      step();
      s    = 1'b0;
      lat = 0; nwr = 0; nlda = 0; nldc = 0; nlds = 0;
      while (!w && lat < 20) begin
         nwr  += int'(write);
         nlda += int'(loada);
         nldc += int'(loadc);
         nlds += int'(loads);
         step();
         lat++;
      end
      if (lat >= 20) chk("timeout_wait_w", 32'(w), 32'd1);
   endtask

   task automatic cmp_state(input string tag);
      for (int i = 0; i < 8; i++)
         chk($sformatf("%s_R%0d", tag, i), 32'(dp_R[i]), 32'(ref_R[i]));
      chk({tag, "_status"}, 32'(dp_status), 32'(ref_status));
   endtask

   typedef struct {
      logic [15:0] ins;
      int lat;
      int wr;
      int lda;
      int ldc;
      int lds;
   } vec_t;

   vec_t vecs [11];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int lat, nwr, nlda, nldc, nlds, elat, ewr;
      logic [15:0] ins;
      logic [2:0]  bad [6];

      vecs[0]  = '{16'hD102, 2, 1, 0, 0, 0};
      vecs[1]  = '{16'hD203, 2, 1, 0, 0, 0};
      vecs[2]  = '{16'hA16A, 5, 1, 1, 1, 0};
      vecs[3]  = '{16'hC0A1, 4, 1, 0, 1, 0};
      vecs[4]  = '{16'hB8E1, 4, 1, 0, 1, 0};
      vecs[5]  = '{16'hB182, 5, 1, 1, 1, 0};
      vecs[6]  = '{16'hC0D2, 4, 1, 0, 1, 0};
      vecs[7]  = '{16'hD103, 2, 1, 0, 0, 0};
      vecs[8]  = '{16'hA902, 4, 0, 1, 0, 1};
      vecs[9]  = '{16'hE000, 1, 0, 0, 0, 0};
      vecs[10] = '{16'hC800, 1, 0, 0, 0, 0};
      bad = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b111};

      reset_n = 1'b0; load = 1'b0; s = 1'b0; in = 16'h0;
      repeat (3) step();
      chk("reset_ctrl", 32'({w, vsel, asel, bsel, loada, loadb, loadc, loads, write,
                             readnum, writenum, ALUop, shift}), 32'({1'b1, 18'b0}));
      chk("reset_imm", {datapath_in, sximm5}, 32'h0);
      reset_n = 1'b1;
      step();

      // Reset during WRITE_IMM aborts the write
      in = 16'hD205; load = 1'b1; step(); load = 1'b0;
      s = 1'b1; step(); s = 1'b0; step();
      chk("rst_mid_write_before", 32'(write), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("rst_mid_write", 32'(write), 32'd0);
      chk("rst_mid_w", 32'(w), 32'd1);
      chk("rst_mid_ir", 32'(datapath_in), 32'h0);
      step();
      chk("rst_mid_R2", 32'(dp_R[2]), 32'h0);
      reset_n = 1'b1;
      step();

      // MOV R0,#-5 step by step
      in = 16'hD0FB; load = 1'b1; step(); load = 1'b0;
      s = 1'b1; step(); s = 1'b0;
      chk("movi_decode_w", 32'(w), 32'd0);
      step();
      chk("movi_write", 32'({write, vsel, writenum}), 32'({1'b1, 1'b0, 3'd0}));
      chk("movi_sximm8", 32'(datapath_in), 32'hFFFB);
      step();
      chk("movi_done_w", 32'(w), 32'd1);
      ref_exec(16'hD0FB, elat, ewr);
      chk("movi_R0", 32'(dp_R[0]), 32'h0000FFFB);

      // ADD R3,R1,R2,LSL#1 with R1=2, R2=3, and load lockout mid-instruction
      run_instr(16'hD102, lat, nwr, nlda, nldc, nlds); ref_exec(16'hD102, elat, ewr);
      run_instr(16'hD203, lat, nwr, nlda, nldc, nlds); ref_exec(16'hD203, elat, ewr);
      in = 16'hA16A; load = 1'b1; step(); load = 1'b0;
      s = 1'b1; step(); s = 1'b0;
      step();
      chk("add_getA", 32'({loada, loadb, readnum, shift}), 32'({1'b1, 1'b0, 3'd1, 2'd0}));
      step();
      chk("add_getB", 32'({loada, loadb, readnum, shift}), 32'({1'b0, 1'b1, 3'd2, 2'd1}));
      in = 16'hFFFF; load = 1'b1;
      step();
      chk("add_exec", 32'({loadc, loads, asel, bsel, ALUop, shift}),
          32'({1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1}));
      chk("add_lockout_ir", 32'(datapath_in), 32'h006A);
      step();
      load = 1'b0;
      chk("add_wreg", 32'({write, vsel, writenum}), 32'({1'b1, 1'b1, 3'd3}));
      step();
      chk("add_done_w", 32'(w), 32'd1);
      chk("add_R3", 32'(dp_R[3]), 32'd8);
      ref_exec(16'hA16A, elat, ewr);

      for (int i = 0; i < 11; i++) begin
         run_instr(vecs[i].ins, lat, nwr, nlda, nldc, nlds);
         ref_exec(vecs[i].ins, elat, ewr);
         chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
         chk($sformatf("vec%0d_wr", i), 32'(nwr), 32'(vecs[i].wr));
         chk($sformatf("vec%0d_lda", i), 32'(nlda), 32'(vecs[i].lda));
         chk($sformatf("vec%0d_ldc", i), 32'(nldc), 32'(vecs[i].ldc));
         chk($sformatf("vec%0d_lds", i), 32'(nlds), 32'(vecs[i].lds));
         cmp_state($sformatf("vec%0d", i));
      end

      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 7))
            0, 1:    ins = {5'b11010, 11'($urandom)};
            2:       ins = {5'b11000, 11'($urandom)};
            3:       ins = {5'b10100, 11'($urandom)};
            4:       ins = {5'b10101, 11'($urandom)};
            5:       ins = {5'b10110, 11'($urandom)};
            6:       ins = {5'b10111, 11'($urandom)};
            default: ins = {bad[$urandom_range(0, 5)], 13'($urandom)};
         endcase
         run_instr(ins, lat, nwr, nlda, nldc, nlds);
         ref_exec(ins, elat, ewr);
         chk($sformatf("rnd%0d_%h_lat", i, ins), 32'(lat), 32'(elat));
         chk($sformatf("rnd%0d_%h_wr", i, ins), 32'(nwr), 32'(ewr));
         cmp_state($sformatf("rnd%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
